// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - MIPS opcode/funct constants, ALU ops and encoder operation kinds
package cpu_types_pkg;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00,
        OP_J       = 6'h02,
        OP_JAL     = 6'h03,
        OP_BEQ     = 6'h04,
        OP_BNE     = 6'h05,
        OP_ADDI    = 6'h08,
        OP_ADDIU   = 6'h09,
        OP_SLTI    = 6'h0A,
        OP_SLTIU   = 6'h0B,
        OP_ANDI    = 6'h0C,
        OP_ORI     = 6'h0D,
        OP_XORI    = 6'h0E,
        OP_LUI     = 6'h0F,
        OP_LW      = 6'h23,
        OP_SW      = 6'h2B,
        OP_HALT    = 6'h3F
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00,
        FN_SRL  = 6'h02,
        FN_JR   = 6'h08,
        FN_ADD  = 6'h20,
        FN_ADDU = 6'h21,
        FN_SUB  = 6'h22,
        FN_SUBU = 6'h23,
        FN_AND  = 6'h24,
        FN_OR   = 6'h25,
        FN_XOR  = 6'h26,
        FN_NOR  = 6'h27,
        FN_SLT  = 6'h2A,
        FN_SLTU = 6'h2B
    } funct_t;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9
    } aluop_t;

    // Kind codes 12..15 are unused and treated as illegal by the encoder.
    typedef enum logic [3:0] {
        ENC_RALU   = 4'd0,
        ENC_SHIFT  = 4'd1,
        ENC_IALU   = 4'd2,
        ENC_LOAD   = 4'd3,
        ENC_STORE  = 4'd4,
        ENC_BRANCH = 4'd5,
        ENC_JUMP   = 4'd6,
        ENC_JAL    = 4'd7,
        ENC_JR     = 4'd8,
        ENC_LUI    = 4'd9,
        ENC_LI32   = 4'd10,
        ENC_HALT   = 4'd11
    } enc_kind_t;

    // Immediate survives sign extension from 16 bits.
    function automatic logic fits_s16(input logic [31:0] v);
        return (v[31:15] == 17'h00000) || (v[31:15] == 17'h1FFFF);
    endfunction

    // Immediate survives zero extension from 16 bits.
    function automatic logic fits_u16(input logic [31:0] v);
        return (v[31:16] == 16'h0000);
    endfunction

endpackage

// File: rtl/instr_fmt.sv
// rtl/instr_fmt.sv - combinational word builder with legality and immediate range flags
module instr_fmt
    import cpu_types_pkg::*;
#(
    parameter int STRICT_IMM = 1
) (
    input  logic [3:0]  kind,
    input  aluop_t      aluop,
    input  logic        uns,
    input  logic        bne,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [31:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word0,
    output logic [31:0] word1,
    output logic        two_word,
    output logic        bad
);

    logic    illegal;
    logic    sign_chk;
    logic    zero_chk;
    logic    range_bad;
    funct_t  fn;
    opcode_t op;

    // Select opcode/funct per kind, assemble the word(s) and flag what cannot be encoded.
    always_comb begin
        word0    = '0;
        word1    = '0;
        two_word = 1'b0;
        illegal  = 1'b0;
        sign_chk = 1'b0;
        zero_chk = 1'b0;
        fn       = FN_SLL;
        op       = OP_SPECIAL;
        case (kind)
            ENC_RALU: begin
                case (aluop)
                    ALU_ADD:  fn = uns ? FN_ADDU : FN_ADD;
                    ALU_SUB:  fn = uns ? FN_SUBU : FN_SUB;
                    ALU_AND:  fn = FN_AND;
                    ALU_OR:   fn = FN_OR;
                    ALU_XOR:  fn = FN_XOR;
                    ALU_NOR:  fn = FN_NOR;
                    ALU_SLT:  fn = FN_SLT;
                    ALU_SLTU: fn = FN_SLTU;
                    default:  illegal = 1'b1;
                endcase
                word0 = {OP_SPECIAL, rs, rt, rd, 5'd0, fn};
            end
            ENC_SHIFT: begin
                case (aluop)
                    ALU_SLL: fn = FN_SLL;
                    ALU_SRL: fn = FN_SRL;
                    default: illegal = 1'b1;
                endcase
                word0 = {OP_SPECIAL, 5'd0, rt, rd, shamt, fn};
            end
            ENC_IALU: begin
                case (aluop)
                    ALU_ADD:  begin op = uns ? OP_ADDIU : OP_ADDI; sign_chk = 1'b1; end
                    ALU_SLT:  begin op = OP_SLTI;  sign_chk = 1'b1; end
                    ALU_SLTU: begin op = OP_SLTIU; sign_chk = 1'b1; end
                    ALU_AND:  begin op = OP_ANDI;  zero_chk = 1'b1; end
                    ALU_OR:   begin op = OP_ORI;   zero_chk = 1'b1; end
                    ALU_XOR:  begin op = OP_XORI;  zero_chk = 1'b1; end
                    default:  illegal = 1'b1;
                endcase
                word0 = {op, rs, rt, imm[15:0]};
            end
            ENC_LOAD: begin
                sign_chk = 1'b1;
                word0    = {OP_LW, rs, rt, imm[15:0]};
            end
            ENC_STORE: begin
                sign_chk = 1'b1;
                word0    = {OP_SW, rs, rt, imm[15:0]};
            end
            ENC_BRANCH: begin
                sign_chk = 1'b1;
                word0    = {(bne ? OP_BNE : OP_BEQ), rs, rt, imm[15:0]};
            end
            ENC_JUMP: word0 = {OP_J, target};
            ENC_JAL:  word0 = {OP_JAL, target};
            ENC_JR:   word0 = {OP_SPECIAL, rs, 15'd0, FN_JR};
            ENC_LUI:  word0 = {OP_LUI, 5'd0, rt, imm[15:0]};
            ENC_LI32: begin
                // Use a single instruction whenever one half of the constant is zero.
                if (imm[31:16] == 16'h0000) begin
                    word0 = {OP_ORI, 5'd0, rt, imm[15:0]};
                end else if (imm[15:0] == 16'h0000) begin
                    word0 = {OP_LUI, 5'd0, rt, imm[31:16]};
                end else begin
                    word0    = {OP_LUI, 5'd0, rt, imm[31:16]};
                    word1    = {OP_ORI, rt, rt, imm[15:0]};
                    two_word = 1'b1;
                end
            end
            ENC_HALT: word0 = {OP_HALT, 26'd0};
            default:  illegal = 1'b1;
        endcase
        range_bad = (STRICT_IMM != 0) &&
                    ((sign_chk && !fits_s16(imm)) || (zero_chk && !fits_u16(imm)));
        bad = illegal || range_bad;
    end

endmodule

// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - decoded-op to MIPS word stream encoder; ENC_DELAY_SLOT_EN adds NOP delay-slot filler
module instr_encoder
    import cpu_types_pkg::*;
#(
    parameter int          STRICT_IMM = 1,
    parameter logic [31:0] NOP_WORD   = 32'h00000000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        enc_valid,
    output logic        enc_ready,
    input  logic [3:0]  enc_kind,
    input  aluop_t      enc_aluop,
    input  logic        enc_uns,
    input  logic        enc_bne,
    input  logic [4:0]  enc_rs,
    input  logic [4:0]  enc_rt,
    input  logic [4:0]  enc_rd,
    input  logic [4:0]  enc_shamt,
    input  logic [31:0] enc_imm,
    input  logic [25:0] enc_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    output logic        enc_err
);

`ifdef ENC_DELAY_SLOT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_SLOT} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_LO} state_t;
`endif

    state_t      state_q;
    logic        instr_valid_q;
    logic [31:0] instr_q;
    logic        instr_last_q;
    logic        enc_err_q;
    logic [31:0] pend_q;

    logic [31:0] f_word0;
    logic [31:0] f_word1;
    logic        f_two;
    logic        f_bad;
    logic        out_free;
    logic        accept;
    logic        drain;

    instr_fmt #(
        .STRICT_IMM (STRICT_IMM)
    ) u_fmt (
        .kind     (enc_kind),
        .aluop    (enc_aluop),
        .uns      (enc_uns),
        .bne      (enc_bne),
        .rs       (enc_rs),
        .rt       (enc_rt),
        .rd       (enc_rd),
        .shamt    (enc_shamt),
        .imm      (enc_imm),
        .target   (enc_target),
        .word0    (f_word0),
        .word1    (f_word1),
        .two_word (f_two),
        .bad      (f_bad)
    );

    assign drain     = instr_valid_q && instr_ready;
    assign out_free  = !instr_valid_q || instr_ready;
    assign enc_ready = (state_q == ST_IDLE) && out_free;
    assign accept    = enc_valid && enc_ready;

`ifdef ENC_DELAY_SLOT_EN
    logic is_ctl;
    assign is_ctl = (enc_kind == ENC_BRANCH) || (enc_kind == ENC_JUMP) ||
                    (enc_kind == ENC_JAL)    || (enc_kind == ENC_JR);
`endif

    // Expansion FSM plus the one-entry output register; the second word is latched at accept.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            state_q       <= ST_IDLE;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_last_q  <= 1'b0;
            enc_err_q     <= 1'b0;
            pend_q        <= NOP_WORD;
        end else begin
            enc_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (f_bad) begin
                            instr_valid_q <= 1'b0;
                            enc_err_q     <= 1'b1;
                        end else begin
                            instr_q       <= f_word0;
                            instr_valid_q <= 1'b1;
                            pend_q        <= f_word1;
                            if (f_two) begin
                                instr_last_q <= 1'b0;
                                state_q      <= ST_LO;
`ifdef ENC_DELAY_SLOT_EN
                            end else if (is_ctl) begin
                                instr_last_q <= 1'b0;
                                state_q      <= ST_SLOT;
`endif
                            end else begin
                                instr_last_q <= 1'b1;
                            end
                        end
                    end else if (drain) begin
                        instr_valid_q <= 1'b0;
                    end
                end
                ST_LO: begin
                    if (out_free) begin
                        instr_q       <= pend_q;
                        instr_valid_q <= 1'b1;
                        instr_last_q  <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
`ifdef ENC_DELAY_SLOT_EN
                ST_SLOT: begin
                    if (out_free) begin
                        instr_q       <= NOP_WORD;
                        instr_valid_q <= 1'b1;
                        instr_last_q  <= 1'b1;
                        state_q       <= ST_IDLE;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_last  = instr_last_q;
    assign enc_err     = enc_err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - scoreboard bench for instr_encoder (honours ENC_DELAY_SLOT_EN)
module tb_instr_encoder;
    import cpu_types_pkg::*;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        enc_valid;
    logic        enc_ready;
    logic [3:0]  enc_kind;
    aluop_t      enc_aluop;
    logic        enc_uns;
    logic        enc_bne;
    logic [4:0]  enc_rs;
    logic [4:0]  enc_rt;
    logic [4:0]  enc_rd;
    logic [4:0]  enc_shamt;
    logic [31:0] enc_imm;
    logic [25:0] enc_target;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        instr_last;
    logic        enc_err;

    typedef struct packed {
        logic [31:0] w;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   err_seen = 0;
    int   err_exp  = 0;
    int   cyc      = 0;
    int   t0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder #(
        .STRICT_IMM (1),
        .NOP_WORD   (32'h00000000)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enc_valid   (enc_valid),
        .enc_ready   (enc_ready),
        .enc_kind    (enc_kind),
        .enc_aluop   (enc_aluop),
        .enc_uns     (enc_uns),
        .enc_bne     (enc_bne),
        .enc_rs      (enc_rs),
        .enc_rt      (enc_rt),
        .enc_rd      (enc_rd),
        .enc_shamt   (enc_shamt),
        .enc_imm     (enc_imm),
        .enc_target  (enc_target),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_last  (instr_last),
        .enc_err     (enc_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w, input logic l);
        exp_t e;
        e.w = w;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Control-transfer word, followed by the filler when delay slots are built in.
    task automatic push_ctl(input logic [31:0] w);
`ifdef ENC_DELAY_SLOT_EN
        push(w, 1'b0);
        push(32'h00000000, 1'b1);
`else
        push(w, 1'b1);
`endif
    endtask

    // Present one operation and hold it until accepted; scramble operands afterwards.
    task automatic issue(input logic [3:0] k, input aluop_t op, input logic uns, input logic bne,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [4:0] sh, input logic [31:0] imm, input logic [25:0] tgt);
        bit acc;
        enc_kind   = k;
        enc_aluop  = op;
        enc_uns    = uns;
        enc_bne    = bne;
        enc_rs     = rs;
        enc_rt     = rt;
        enc_rd     = rd;
        enc_shamt  = sh;
        enc_imm    = imm;
        enc_target = tgt;
        enc_valid  = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (enc_ready) acc = 1'b1;
            @(posedge clk);
            #1;
        end
        enc_valid = 1'b0;
        enc_rt    = 5'h1F;
        enc_rs    = 5'h1F;
        enc_imm   = 32'hFFFFFFFF;
        if (!acc) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got enc_ready=0 expected accept within 20 cycles");
        end
    endtask

    // Rejected operation: one enc_err pulse, no word.
    task automatic issue_err(input string name, input logic [3:0] k, input aluop_t op,
                             input logic [31:0] imm);
        err_exp++;
        issue(k, op, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, imm, 26'd0);
        @(negedge clk);
        check({name, "_err_hi"}, {31'd0, enc_err}, 32'd1);
        check({name, "_no_valid"}, {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        check({name, "_err_lo"}, {31'd0, enc_err}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && !instr_valid) break;
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every word taken by the consumer is popped and compared.
    always @(negedge clk) begin
        if (!n_rst && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%08h expected none", instr);
            end else begin
                mon_e = exp_q.pop_front();
                check("instr_word", instr, mon_e.w);
                check("instr_last", {31'd0, instr_last}, {31'd0, mon_e.l});
            end
        end
        if (!n_rst && enc_err) err_seen++;
    end

    initial begin
        n_rst       = 1'b1;
        enc_valid   = 1'b0;
        enc_kind    = 4'd0;
        enc_aluop   = ALU_ADD;
        enc_uns     = 1'b0;
        enc_bne     = 1'b0;
        enc_rs      = 5'd0;
        enc_rt      = 5'd0;
        enc_rd      = 5'd0;
        enc_shamt   = 5'd0;
        enc_imm     = 32'd0;
        enc_target  = 26'd0;
        instr_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_last", {31'd0, instr_last}, 32'd0);
        check("rst_err", {31'd0, enc_err}, 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b0;

        // ADDU $3,$1,$2
        push(32'h00221821, 1'b1);
        issue(ENC_RALU, ALU_ADD, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0);
        @(negedge clk);
        check("first_latency_valid", {31'd0, instr_valid}, 32'd1);
        @(posedge clk);
        #1;

        // LI32 two-word expansion; enc_ready must drop while LO is pending.
        push(32'h3C081234, 1'b0);
        push(32'h35085678, 1'b1);
        issue(ENC_LI32, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0);
        @(negedge clk);
        check("lo_enc_ready", {31'd0, enc_ready}, 32'd0);
        @(posedge clk);
        #1;

        push(32'h3408FFFF, 1'b1);
        issue(ENC_LI32, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000FFFF, 26'd0);
        push(32'h3C03DEAD, 1'b1);
        issue(ENC_LI32, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 5'd0, 32'hDEAD0000, 26'd0);

        // Back-to-back single-word ops: one accept per cycle.
        push(32'hFC000000, 1'b1);
        push(32'h3C01ABCD, 1'b1);
        push(32'h00021900, 1'b1);
        push(32'h00853022, 1'b1);
        t0 = cyc;
        issue(ENC_HALT, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
        issue(ENC_LUI, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd0, 32'h0000ABCD, 26'd0);
        issue(ENC_SHIFT, ALU_SLL, 1'b0, 1'b0, 5'd0, 5'd2, 5'd3, 5'd4, 32'd0, 26'd0);
        issue(ENC_RALU, ALU_SUB, 1'b0, 1'b0, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, 26'd0);
        check("b2b_cycles", cyc - t0, 32'd4);

        // Immediate-form and memory ops, including range boundaries that fit.
        push(32'h34A4FFFF, 1'b1);
        issue(ENC_IALU, ALU_OR, 1'b0, 1'b0, 5'd5, 5'd4, 5'd0, 5'd0, 32'h0000FFFF, 26'd0);
        push(32'h23BDFFFC, 1'b1);
        issue(ENC_IALU, ALU_ADD, 1'b0, 1'b0, 5'd29, 5'd29, 5'd0, 5'd0, 32'hFFFFFFFC, 26'd0);
        push(32'h20018000, 1'b1);
        issue(ENC_IALU, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF8000, 26'd0);
        push(32'h8FA20004, 1'b1);
        issue(ENC_LOAD, ALU_ADD, 1'b0, 1'b0, 5'd29, 5'd2, 5'd0, 5'd0, 32'h00000004, 26'd0);
        push(32'hAFA20008, 1'b1);
        issue(ENC_STORE, ALU_ADD, 1'b0, 1'b0, 5'd29, 5'd2, 5'd0, 5'd0, 32'h00000008, 26'd0);

        // Control transfers.
        push_ctl(32'h1422FFFF);
        issue(ENC_BRANCH, ALU_ADD, 1'b0, 1'b1, 5'd1, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 26'd0);
        push_ctl(32'h08000010);
        issue(ENC_JUMP, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h0000010);
        push_ctl(32'h0C100000);
        issue(ENC_JAL, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 26'h0100000);
        push_ctl(32'h03E00008);
        issue(ENC_JR, ALU_ADD, 1'b0, 1'b0, 5'd31, 5'd0, 5'd0, 5'd0, 32'd0, 26'd0);
        wait_drain();

        // Rejections: range failures and illegal combinations.
        issue_err("addi_range", ENC_IALU, ALU_ADD, 32'h00012345);
        issue_err("addi_8000", ENC_IALU, ALU_ADD, 32'h00008000);
        issue_err("andi_range", ENC_IALU, ALU_AND, 32'hFFFF8000);
        issue_err("ialu_sub", ENC_IALU, ALU_SUB, 32'h00000001);
        issue_err("bad_kind", 4'd12, ALU_ADD, 32'h00000000);
        wait_drain();

        // Backpressure holds the LUI stable; reset in LO discards the ORI.
        instr_ready = 1'b0;
        push(32'h3C081234, 1'b0);
        push(32'h35085678, 1'b1);
        issue(ENC_LI32, ALU_ADD, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 5'd0, 32'h12345678, 26'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, 32'h3C081234);
            check("stall_last", {31'd0, instr_last}, 32'd0);
            @(posedge clk);
            #1;
        end
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        exp_q.delete();
        instr_ready = 1'b1;
        @(negedge clk);
        check("rst_lo_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_lo_enc_ready", {31'd0, enc_ready}, 32'd1);
        repeat (5) @(posedge clk);
        #1;

        // Encoder still works after the mid-expansion reset.
        push(32'h00221821, 1'b1);
        issue(ENC_RALU, ALU_ADD, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 26'd0);
        wait_drain();

        check("queue_empty", exp_q.size(), 32'd0);
        check("err_pulses", err_seen, err_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
